// File: rtl/cyq_seq_det_ctrl.sv
// Test sequencer for a serial "011" Moore detector: clears it, shifts a word out MSB-first, collects matches.
// Start to Done is WORD_W+3 cycles; Start is only accepted in IDLE, so a held Start re-runs every WORD_W+4 cycles.
module cyq_seq_det_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [WORD_W-1:0] Din,
   input  logic              Y_in,
   output logic              X_out,
   output logic              Det_rst,
   output logic              Busy,
   output logic              Done,
   output logic [CNT_W-1:0]  Match_cnt,
   output logic [WORD_W-1:0] Match_pos
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_SHIFT,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] sreg, sreg_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [WORD_W-1:0] pos_nxt;
   logic              sample;
   logic [IDX_W-1:0]  samp_idx;

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      idx_nxt   = idx;
      cnt_nxt   = Match_cnt;
      pos_nxt   = Match_pos;
      sample    = 1'b0;
      samp_idx  = LAST_IDX;
      case (state)
         S_IDLE: begin
            if (Start) begin
               sreg_nxt  = Din;
               cnt_nxt   = '0;
               pos_nxt   = '0;
               state_nxt = S_CLR;
            end
         end
         S_CLR: begin
            idx_nxt   = '0;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            sreg_nxt = {sreg[WORD_W-2:0], 1'b0};
            idx_nxt  = idx + 1'b1;
            // Y lags X by one cycle: what we see now belongs to the previous serial bit.
            sample   = (idx != '0);
            samp_idx = idx - 1'b1;
            if (idx == LAST_IDX) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            sample    = 1'b1;
            samp_idx  = LAST_IDX;
            state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (sample && Y_in) begin
         pos_nxt = pos_nxt | (WORD_W'(1) << samp_idx);
         if (Match_cnt != CNT_MAX) cnt_nxt = Match_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= S_IDLE;
         sreg      <= '0;
         idx       <= '0;
         Match_cnt <= '0;
         Match_pos <= '0;
         Det_rst   <= 1'b1;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         idx       <= idx_nxt;
         Match_cnt <= cnt_nxt;
         Match_pos <= pos_nxt;
         Det_rst   <= (state_nxt == S_CLR);
      end
   end

   assign X_out = (state == S_SHIFT) & sreg[WORD_W-1];
   assign Busy  = (state != S_IDLE);
   assign Done  = (state == S_DONE);

endmodule

// File: tb/tb_cyq_seq_det_ctrl.sv
// Bench for cyq_seq_det_ctrl: behavioural "011" detector in the loop plus a saturation instance with Y tied high.
module tb_cyq_seq_det_ctrl;

   logic       Clk, Rst, Start;
   logic [7:0] Din;
   logic       Y_in, X_out, Det_rst, Busy, Done;
   logic [3:0] Match_cnt;
   logic [7:0] Match_pos;

   logic       y_one;
   logic       s_x, s_det_rst, s_busy, s_done;
   logic [1:0] s_cnt;
   logic [7:0] s_pos;

   logic [1:0] det_st;

   typedef struct packed {
      logic [3:0] cnt;
      logic [7:0] pos;
   } exp_t;
   exp_t sb_q[$];

   int n_vec, n_err, cyc, n_done, last_done;

   cyq_seq_det_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din), .Y_in(Y_in),
      .X_out(X_out), .Det_rst(Det_rst), .Busy(Busy), .Done(Done),
      .Match_cnt(Match_cnt), .Match_pos(Match_pos)
   );

   cyq_seq_det_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din), .Y_in(y_one),
      .X_out(s_x), .Det_rst(s_det_rst), .Busy(s_busy), .Done(s_done),
      .Match_cnt(s_cnt), .Match_pos(s_pos)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference "011" Moore detector: 0 = idle, 1 = saw 0, 2 = saw 01, 3 = saw 011.
   always @(posedge Clk) begin
      if (Det_rst) det_st <= 2'd0;
      else begin
         case (det_st)
            2'd0:    det_st <= X_out ? 2'd0 : 2'd1;
            2'd1:    det_st <= X_out ? 2'd2 : 2'd1;
            2'd2:    det_st <= X_out ? 2'd3 : 2'd1;
            default: det_st <= X_out ? 2'd0 : 2'd1;
         endcase
      end
   end
   assign Y_in = (det_st == 2'd3);

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge Clk);
      #1;
      cyc++;
      if (Done === 1'b1) begin
         n_done++;
         last_done = cyc;
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_pop observed=Done at cycle %0d expected=no Done", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("match_cnt", 32'(Match_cnt), 32'(e.cnt));
            chk("match_pos", 32'(Match_pos), 32'(e.pos));
            chk("sat_cnt",   32'(s_cnt),     32'd3);
            chk("sat_pos",   32'(s_pos),     32'hFF);
         end
      end
   endtask

   task automatic run_full(input logic [7:0] din, input logic [3:0] ecnt, input logic [7:0] epos);
      int t;
      Start = 1'b1;
      Din   = din;
      sb_q.push_back('{cnt: ecnt, pos: epos});
      t = cyc;
      tick();
      Start = 1'b0;
      Din   = 8'($urandom);
      chk("clr_det_rst", 32'(Det_rst), 32'd1);
      chk("clr_busy",    32'(Busy),    32'd1);
      chk("clr_x",       32'(X_out),   32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("x_out_k%0d", k),   32'(X_out),   32'(din[7-k]));
         chk($sformatf("det_rst_k%0d", k), 32'(Det_rst), 32'd0);
      end
      tick();
      chk("flush_x",    32'(X_out), 32'd0);
      chk("flush_done", 32'(Done),  32'd0);
      tick();
      chk("done_pulse",   32'(Done),    32'd1);
      chk("done_latency", 32'(cyc - t), 32'd11);
      chk("done_det_rst", 32'(Det_rst), 32'd0);
      tick();
      chk("idle_done", 32'(Done), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);
   endtask

   initial begin
      int t, n0, d1;
      n_vec = 0; n_err = 0; cyc = 0; n_done = 0; last_done = 0;
      Rst = 1'b1; Start = 1'b0; Din = 8'h00; y_one = 1'b1;

      tick();
      tick();
      chk("rst_det_rst", 32'(Det_rst),   32'd1);
      chk("rst_busy",    32'(Busy),      32'd0);
      chk("rst_done",    32'(Done),      32'd0);
      chk("rst_x",       32'(X_out),     32'd0);
      chk("rst_cnt",     32'(Match_cnt), 32'd0);
      chk("rst_pos",     32'(Match_pos), 32'd0);
      Rst = 1'b0;
      tick();
      chk("det_rst_release", 32'(Det_rst), 32'd0);

      run_full(8'b0110_0110, 4'd2, 8'h44);
      // Results must hold through idle cycles while Din wanders.
      for (int i = 0; i < 3; i++) begin
         Din = 8'($urandom);
         tick();
      end
      chk("hold_cnt", 32'(Match_cnt), 32'd2);
      chk("hold_pos", 32'(Match_pos), 32'h44);

      run_full(8'b0011_0011, 4'd2, 8'h88);
      run_full(8'hFF, 4'd0, 8'h00);
      run_full(8'h00, 4'd0, 8'h00);
      run_full(8'h01, 4'd0, 8'h00);
      run_full(8'b1000_0000, 4'd0, 8'h00);

      // Start re-pulsed during SHIFT and during DONE must be ignored.
      n0 = n_done;
      Start = 1'b1;
      Din   = 8'h66;
      sb_q.push_back('{cnt: 4'd2, pos: 8'h44});
      t = cyc;
      tick();
      Start = 1'b0;
      Din   = 8'h00;
      tick();
      tick();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 20 && cyc < t + 11; i++) tick();
      chk("repulse_in_done", 32'(Done), 32'd1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("repulse_busy", 32'(Busy), 32'd0);
      for (int i = 0; i < 14; i++) tick();
      chk("repulse_done_count", 32'(n_done - n0),    32'd1);
      chk("repulse_done_cyc",   32'(last_done - t),  32'd11);

      // Held Start: back-to-back runs 12 cycles apart.
      n0 = n_done;
      d1 = -1;
      Start = 1'b1;
      Din   = 8'h33;
      sb_q.push_back('{cnt: 4'd2, pos: 8'h88});
      sb_q.push_back('{cnt: 4'd2, pos: 8'h88});
      t = cyc;
      for (int i = 0; i < 40 && n_done < n0 + 2; i++) begin
         tick();
         if (n_done == n0 + 1 && d1 < 0) d1 = cyc;
      end
      Start = 1'b0;
      chk("held_done_count", 32'(n_done - n0),   32'd2);
      chk("held_first_done", 32'(d1 - t),        32'd11);
      chk("held_spacing",    32'(last_done - d1), 32'd12);
      tick();
      chk("held_stop_busy", 32'(Busy), 32'd0);

      // Reset in SHIFT k=4 (one match already recorded by then).
      Start = 1'b1;
      Din   = 8'h66;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_cnt", 32'(Match_cnt), 32'd1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("midrst_busy",    32'(Busy),      32'd0);
      chk("midrst_done",    32'(Done),      32'd0);
      chk("midrst_cnt",     32'(Match_cnt), 32'd0);
      chk("midrst_pos",     32'(Match_pos), 32'd0);
      chk("midrst_det_rst", 32'(Det_rst),   32'd1);
      chk("midrst_sat_pos", 32'(s_pos),     32'd0);
      tick();
      chk("midrst_release", 32'(Det_rst), 32'd0);
      run_full(8'h66, 4'd2, 8'h44);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
